// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter.
package wb_pkg;
  localparam int XLEN_DEF = 64;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] XZR_ADDR = 5'd31;

  typedef struct packed {
    logic [REG_AW-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

  function automatic logic is_xzr(input logic [REG_AW-1:0] addr);
    return addr == XZR_ADDR;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Result FIFO for the multi-cycle unit; exports per-entry addr/valid for hazard queries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 push,
  input  wb_req_t                              push_req,
  input  logic                                 pop,
  output wb_req_t                              head,
  output logic [$clog2(DEPTH+1)-1:0]           level,
  output logic [DEPTH-1:0][REG_AW-1:0]         ent_addr,
  output logic [DEPTH-1:0]                     ent_vld
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  wb_req_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: ent_vld masks anything not yet written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  assign head = mem[rd_ptr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off         = PW'(i) - rd_ptr;
    assign ent_addr[i] = mem[i].addr;
    assign ent_vld[i]  = LW'(off) < level;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipeline results win the regfile port, multi-cycle results queue and drain into idle slots.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         a_valid,
  input  logic [REG_AW-1:0]            a_addr,
  input  logic [XLEN-1:0]              a_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [REG_AW-1:0]            b_addr,
  input  logic [XLEN-1:0]              b_data,
  output logic                         we3,
  output logic [REG_AW-1:0]            wa3,
  output logic [XLEN-1:0]              wd3,
  input  logic [REG_AW-1:0]            q_addr,
  output logic                         q_pending,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  wb_req_t                      a_req, b_req, head, sel;
  logic                         a_ok, b_hs, b_ok, empty, pop, bypass, push, load;
  logic [DEPTH-1:0][REG_AW-1:0] ent_addr;
  logic [DEPTH-1:0]             ent_vld, hit;

  assign a_req = '{addr: a_addr, data: XLEN_DEF'(a_data)};
  assign b_req = '{addr: b_addr, data: XLEN_DEF'(b_data)};

  // Space is judged on the current level only; a same-cycle pop does not help.
  assign b_ready = reset_n && (int'(level) < DEPTH);
  assign b_hs    = b_valid && b_ready;
  assign a_ok    = a_valid && !is_xzr(a_addr);
  assign b_ok    = b_hs && !is_xzr(b_addr);
  assign empty   = level == '0;
  assign pop     = !a_ok && !empty;
  assign bypass  = !a_ok && empty && b_ok;
  assign push    = b_ok && !bypass;
  assign load    = a_ok || pop || bypass;

  always_comb begin
    sel = b_req;
    if (a_ok)     sel = a_req;
    else if (pop) sel = head;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_req (b_req),
    .pop      (pop),
    .head     (head),
    .level    (level),
    .ent_addr (ent_addr),
    .ent_vld  (ent_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= load;
      if (load) begin
        wa3 <= sel.addr;
        wd3 <= sel.data[XLEN-1:0];
      end
    end
  end

  // The regfile has no internal bypass, so the write landing this edge still counts.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = ent_vld[i] && (ent_addr[i] == q_addr);
  end

  assign q_pending = !is_xzr(q_addr) && (|hit || (we3 && wa3 == q_addr));
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: priority, bypass, FIFO fill/drain, query and async reset.
module tb_wb_arbiter;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clk = 0;
  logic            reset_n;
  logic            a_valid, b_valid, b_ready, we3, q_pending;
  logic [4:0]      a_addr, b_addr, wa3, q_addr;
  logic [XLEN-1:0] a_data, b_data, wd3;
  logic [2:0]      level;

  int tests = 0;
  int errors = 0;

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .q_addr(q_addr), .q_pending(q_pending), .level(level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0; a_valid = 0; b_valid = 0;
    a_addr = 0; a_data = 0; b_addr = 0; b_data = 0; q_addr = 0;
    #12;
    tests++; if (we3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %b exp 0", we3); end
    tests++; if (wa3 !== 5'd0 || wd3 !== '0) begin errors++; $display("FAIL reset_wa3_wd3 got %0d/%0h exp 0/0", wa3, wd3); end
    tests++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    tests++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready got %b exp 0", b_ready); end
    @(posedge clk); #1;
    reset_n = 1;
    #1;
    tests++; if (b_ready !== 1'b1) begin errors++; $display("FAIL post_reset_b_ready got %b exp 1", b_ready); end
  endtask

  task automatic test_a_write();
    a_valid = 1; a_addr = 23; a_data = 46;
    step();
    a_valid = 0;
    tests++; if (we3 !== 1'b1 || wa3 !== 5'd23 || wd3 !== 64'd46) begin
      errors++; $display("FAIL a_write got we3=%b wa3=%0d wd3=%0d exp 1/23/46", we3, wa3, wd3); end
    step();
    tests++; if (we3 !== 1'b0 || wa3 !== 5'd23) begin
      errors++; $display("FAIL a_idle got we3=%b wa3=%0d exp 0/23", we3, wa3); end
  endtask

  task automatic test_xzr();
    a_valid = 1; a_addr = 31; a_data = 23;
    step();
    a_valid = 0;
    tests++; if (we3 !== 1'b0) begin errors++; $display("FAIL xzr_a got we3=%b exp 0", we3); end
    b_valid = 1; b_addr = 31; b_data = 64'h55;
    #1;
    tests++; if (b_ready !== 1'b1) begin errors++; $display("FAIL xzr_b_ready got %b exp 1", b_ready); end
    step();
    b_valid = 0;
    tests++; if (we3 !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL xzr_b got we3=%b level=%0d exp 0/0", we3, level); end
  endtask

  task automatic test_bypass();
    b_valid = 1; b_addr = 5; b_data = 64'hAA;
    step();
    b_valid = 0;
    tests++; if (we3 !== 1'b1 || wa3 !== 5'd5 || wd3 !== 64'hAA || level !== 3'd0) begin
      errors++; $display("FAIL bypass got we3=%b wa3=%0d wd3=%0h level=%0d exp 1/5/aa/0", we3, wa3, wd3, level); end
    step();
  endtask

  task automatic test_fill_drain();
    logic [5:0] exp_rdy;
    logic [4:0] exp_wa [5];
    int bidx;
    exp_rdy = 6'b001111;  // bit i = b_ready expected in A cycle i
    exp_wa  = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
    bidx = 0;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1; a_addr = 5'(i + 1); a_data = 64'(i + 100);
      b_valid = 1; b_addr = 5'(10 + bidx); b_data = 64'(200 + bidx);
      #1;
      tests++; if (b_ready !== exp_rdy[i]) begin
        errors++; $display("FAIL fill_ready[%0d] got %b exp %b", i, b_ready, exp_rdy[i]); end
      if (b_ready) bidx++;
      step();
      tests++; if (we3 !== 1'b1 || wa3 !== 5'(i + 1) || wd3 !== 64'(i + 100)) begin
        errors++; $display("FAIL fill_a[%0d] got we3=%b wa3=%0d exp 1/%0d", i, we3, wa3, i + 1); end
    end
    a_valid = 0;
    tests++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d exp 4", level); end
    for (int i = 0; i < 5; i++) begin
      b_addr = 5'(10 + bidx); b_data = 64'(200 + bidx);
      b_valid = (bidx < 5);
      #1;
      if (i == 0) begin
        tests++; if (b_ready !== 1'b0) begin errors++; $display("FAIL drain_ready0 got %b exp 0", b_ready); end
      end
      if (i == 1) begin
        tests++; if (b_ready !== 1'b1) begin errors++; $display("FAIL drain_ready1 got %b exp 1", b_ready); end
      end
      if (b_valid && b_ready) bidx++;
      step();
      tests++; if (we3 !== 1'b1 || wa3 !== exp_wa[i] || wd3 !== 64'(190 + exp_wa[i])) begin
        errors++; $display("FAIL drain[%0d] got we3=%b wa3=%0d wd3=%0d exp 1/%0d/%0d", i, we3, wa3, wd3, exp_wa[i], 190 + exp_wa[i]); end
    end
    b_valid = 0;
    tests++; if (level !== 3'd0) begin errors++; $display("FAIL drain_level got %0d exp 0", level); end
    step();
    tests++; if (we3 !== 1'b0) begin errors++; $display("FAIL drain_idle got we3=%b exp 0", we3); end
  endtask

  task automatic test_query();
    q_addr = 9;
    a_valid = 1; a_addr = 2; a_data = 2;
    b_valid = 1; b_addr = 9; b_data = 64'h99;
    #1;
    tests++; if (q_pending !== 1'b0) begin errors++; $display("FAIL q_before got %b exp 0", q_pending); end
    step();
    b_valid = 0; a_addr = 3; a_data = 3;
    #1;
    tests++; if (q_pending !== 1'b1 || level !== 3'd1) begin
      errors++; $display("FAIL q_queued got q=%b level=%0d exp 1/1", q_pending, level); end
    step();
    a_valid = 0;
    #1;
    tests++; if (q_pending !== 1'b1 || wa3 !== 5'd3) begin
      errors++; $display("FAIL q_held got q=%b wa3=%0d exp 1/3", q_pending, wa3); end
    step();
    tests++; if (q_pending !== 1'b1 || we3 !== 1'b1 || wa3 !== 5'd9 || wd3 !== 64'h99) begin
      errors++; $display("FAIL q_landing got q=%b we3=%b wa3=%0d exp 1/1/9", q_pending, we3, wa3); end
    step();
    tests++; if (q_pending !== 1'b0 || we3 !== 1'b0) begin
      errors++; $display("FAIL q_after got q=%b we3=%b exp 0/0", q_pending, we3); end
    q_addr = 31;
    #1;
    tests++; if (q_pending !== 1'b0) begin errors++; $display("FAIL q_xzr got %b exp 0", q_pending); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_addr = 1; a_data = 1;
      b_valid = 1; b_addr = 5'(20 + i); b_data = 64'(i);
      step();
    end
    a_valid = 0; b_valid = 0;
    tests++; if (level !== 3'd3 || we3 !== 1'b1) begin
      errors++; $display("FAIL mid_fill got level=%0d we3=%b exp 3/1", level, we3); end
    #2;
    reset_n = 0;
    #1;
    tests++; if (we3 !== 1'b0 || level !== 3'd0 || wa3 !== 5'd0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset got we3=%b level=%0d wa3=%0d b_ready=%b exp 0/0/0/0", we3, level, wa3, b_ready); end
    step();
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (we3 !== 1'b0 || level !== 3'd0 || b_ready !== 1'b1) begin
        errors++; $display("FAIL post_mid[%0d] got we3=%b level=%0d b_ready=%b exp 0/0/1", i, we3, level, b_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_xzr();
    test_bypass();
    test_fill_drain();
    test_query();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Write-back stage that drives the regfile single write port (we3/wa3/wd3).
- Merges two result sources: the in-order pipeline (source A, never stalls) and a multi-cycle unit (source B: mul/div, valid/ready handshake).
- B results are buffered in a small FIFO and drained into idle write slots.
- Also answers a pending-write query so decode can stall on a register still in flight.

Parameters:
XLEN, 64, data width of register values
DEPTH, 4, B-side FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
a_valid  in  1  pipeline result valid this cycle (no backpressure)
a_addr  in  5  pipeline destination register
a_data  in  XLEN  pipeline result
b_valid  in  1  multi-cycle unit result valid
b_ready  out  1  FIFO can accept B result
b_addr  in  5  B destination register
b_data  in  XLEN  B result
we3  out  1  regfile write enable (registered)
wa3  out  5  regfile write address (registered)
wd3  out  XLEN  regfile write data (registered)
q_addr  in  5  decode query register
q_pending  out  1  q_addr has an outstanding write (combinational)
level  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async on reset_n low): we3=0, wa3=0, wd3=0, level=0, FIFO pointers=0; b_ready=0 while reset_n low.
- XZR: any request with addr 31 is dropped.
  - A: no write is issued.
  - B: the handshake completes but nothing is enqueued.
  - Register 31 never appears on we3=1.
- B handshake: b_valid && b_ready.
  - b_ready = (level < DEPTH) && reset_n.
  - b_ready is computed on current level; a same-cycle drain does not free space early.
- Per-cycle slot selection, strict priority:
  1. a_valid (addr != 31): output reg <= A next edge; FIFO holds; a B handshake this cycle enqueues.
  2. else FIFO non-empty: pop head into output reg; a B handshake this cycle enqueues at tail (level unchanged).
  3. else FIFO empty and B handshake (addr != 31): bypass, B goes straight to output reg; not enqueued.
  4. else we3 <= 0; wa3/wd3 hold their previous values.
- Latency:
  - A: 1 cycle (we3 high on the cycle after a_valid).
  - B via bypass: 1 cycle.
  - B via FIFO: 1 cycle after the slot in which it is popped.
- Ordering: B results retire in handshake order. A and B order is not preserved. The pipeline guarantees no WAW between A and an outstanding B, using q_pending.
- q_pending = (q_addr != 31) && (any valid FIFO entry addr == q_addr, or (we3 && wa3 == q_addr)).
  - Covers the write landing this edge, since the regfile has no internal bypass.
- FIFO wrap-around: pointers are log2(DEPTH) bits and wrap naturally. level distinguishes full from empty.
- Full, with A continuously valid: B is stalled (b_ready=0) indefinitely. This is acceptable; there is no starvation guarantee.
- Reset mid-operation: FIFO contents are discarded and outputs return to reset values immediately (asynchronous).

Decomposition:
- Package wb_pkg:
  - XZR_ADDR = 5'd31
  - REG_AW = 5
  - typedef wb_req_t {logic [4:0] addr; logic [XLEN-1:0] data;}
  - function is_xzr(addr)
- Sub-module wb_fifo (DEPTH x wb_req_t, push/pop/level, plus per-entry addr/valid vectors exported for the q_pending compare).
- wb_arbiter holds the priority mux, bypass, output register and query logic.

Test Plan:
- Reset then a_valid=1, a_addr=23, a_data=46 -> next cycle we3=1, wa3=23, wd3=46; following cycle we3=0.
- a_valid=1, a_addr=31, a_data=23 -> we3 stays 0. b_valid, b_addr=31 -> b_ready=1, level stays 0, no write.
- Idle A, b_valid with addr=5, data=0xAA -> we3=1, wa3=5, wd3=0xAA after 1 cycle (bypass), level=0.
- Hold a_valid=1 for 6 cycles (addr 1..6) while b_valid with addrs 10,11,12,13,14 -> b_ready drops after 4 accepted, level=4.
  - After A stops, writes 10,11,12,13 appear on consecutive cycles, then 14 is accepted and written.
- B addr=9 queued behind A traffic -> q_addr=9 gives q_pending=1 through the cycle we3=1, wa3=9; 0 the cycle after. q_addr=31 always gives 0.
- Fill FIFO to level=3, assert reset_n=0 mid-cycle -> we3=0 and level=0 immediately.
  - After release, no stale writes appear and b_ready=1.
